// File: rtl/enc_arb_pkg.sv
// rtl/enc_arb_pkg.sv - shared types, sizes and round-robin pick helper for enc_rr_arbiter4
package enc_arb_pkg;

  localparam int REQ_N = 4;
  localparam int IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // First set request bit found scanning upward from ptr, wrapping mod REQ_N.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [REQ_N-1:0] req,
                                               input logic [IDX_W-1:0] ptr);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic             found;
    sel   = ptr;
    found = 1'b0;
    for (int k = 0; k < REQ_N; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/enc_rr_arbiter4_if.sv
// rtl/enc_rr_arbiter4_if.sv - request/grant bundle between requesters and enc_rr_arbiter4
interface enc_rr_arbiter4_if
  import enc_arb_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic [REQ_N-1:0] req;
  logic [REQ_N-1:0] gnt;
  logic             gnt_vld;
  logic [IDX_W-1:0] gnt_idx;
  logic [CNT_W-1:0] act_cnt;

  modport master (
    output req,
    input  gnt,
    input  gnt_vld,
    input  gnt_idx,
    input  act_cnt
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_vld,
    output gnt_idx,
    output act_cnt
  );

endinterface

// File: rtl/encoder4x2.sv
// rtl/encoder4x2.sv - 4-to-2 encoder; highest set bit wins, all-zero input gives 0
module encoder4x2 (
  input  logic [3:0] onehot,
  output logic [1:0] idx
);

  always_comb begin
    idx = 2'd0;
    casez (onehot)
      4'b1???: idx = 2'd3;
      4'b01??: idx = 2'd2;
      4'b001?: idx = 2'd1;
      default: idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/enc_rr_arbiter4.sv
// rtl/enc_rr_arbiter4.sv - 4-way round-robin arbiter with hold-timer preemption and encoded index
// Optional gnt_idx toggle counter is built only when ENC_ARB_ACT_CNT_EN is defined.
module enc_rr_arbiter4
  import enc_arb_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 16
) (
  input logic               clk,
  input logic               rst_n,
  enc_rr_arbiter4_if.slave  bus
);

  localparam int HOLD_LAST = (HOLD_MAX > 0) ? HOLD_MAX - 1 : 0;
  localparam int HOLD_W    = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;

  arb_state_e       state_q, state_d;
  logic [REQ_N-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] idx;
  logic             owner_req;
  logic             rival_req;
  logic             hold_done;

  assign pick      = rr_pick(bus.req, ptr_q);
  assign owner_req = |(bus.req & gnt_q);
  assign rival_req = |(bus.req & ~gnt_q);
  assign hold_done = (HOLD_MAX != 0) && (hold_q == HOLD_W'(HOLD_LAST));

  // Every release returns to IDLE, so ownership never passes directly between requesters.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          gnt_d   = REQ_N'(1) << pick;
          ptr_d   = pick + 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req || (hold_done && rival_req)) begin
          gnt_d   = '0;
          state_d = IDLE;
        end else if (hold_q != HOLD_W'(HOLD_LAST)) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
    end
  end

  encoder4x2 u_enc (
    .onehot (gnt_q),
    .idx    (idx)
  );

  assign bus.gnt     = gnt_q;
  assign bus.gnt_vld = |gnt_q;
  assign bus.gnt_idx = idx;

`ifdef ENC_ARB_ACT_CNT_EN
  logic [IDX_W-1:0] idx_prev;
  logic [IDX_W-1:0] flips;
  logic [CNT_W-1:0] act_q;
  logic [CNT_W:0]   act_sum;

  always_comb begin
    flips = '0;
    for (int b = 0; b < IDX_W; b++) begin
      flips = flips + IDX_W'(idx[b] ^ idx_prev[b]);
    end
  end

  // One spare carry bit detects overflow so the count sticks at all-ones.
  assign act_sum = {1'b0, act_q} + (CNT_W + 1)'(flips);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_prev <= '0;
      act_q    <= '0;
    end else begin
      idx_prev <= idx;
      act_q    <= act_sum[CNT_W] ? {CNT_W{1'b1}} : act_sum[CNT_W-1:0];
    end
  end

  assign bus.act_cnt = act_q;
`else
  assign bus.act_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/enc_rr_arbiter4.md
# enc_rr_arbiter4

Round-robin arbiter that shares the 4-to-2 encoder datapath (`encoder4x2`) between four requesters. It issues a registered one-hot grant and drives the same one-hot vector into an `encoder4x2` instance to produce the binary grant index. It sits in front of the encoder-based test datapaths of the power-estimation flow. An optional switching-activity counter on the index bus feeds the power-estimation flow.

## Interface
- `HOLD_MAX`, 8: maximum consecutive cycles one owner keeps the grant while another request is pending; 0 disables preemption.
- `CNT_W`, 16: activity counter width.
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `req`  in  4  request per requester; held high for the whole transaction.
- `gnt`  out  4  registered one-hot grant, or all-zero.
- `gnt_vld`  out  1  high when `gnt` is non-zero.
- `gnt_idx`  out  2  `encoder4x2` output driven by `gnt`; 0 when `gnt` is 0.
- `act_cnt`  out  CNT_W  number of `gnt_idx` bit toggles, saturating.

## Operation
- Reset values: `gnt`=0, `gnt_vld`=0, `gnt_idx`=0, `act_cnt`=0, `ptr`=0, `hold_cnt`=0, state IDLE.
- Two-state FSM.
- IDLE:
  - If `req`≠0, search in order `ptr`, `ptr`+1, … (mod 4) and pick the first set bit i.
  - Register `gnt`=1<<i, set `ptr`=(i+1) mod 4, clear `hold_cnt`, go to GRANT.
  - If `req`=0, stay in IDLE.
- GRANT, with owner o:
  - If `req[o]`=0: clear `gnt` and go to IDLE.
  - Else if `HOLD_MAX`≠0, `hold_cnt`==`HOLD_MAX`-1 and `req` has another bit set: preempt, i.e. clear `gnt` and go to IDLE.
  - Else: keep the grant and increment `hold_cnt`, saturating at `HOLD_MAX`-1.
- There is never a direct owner-to-owner handover. Every release inserts one IDLE cycle with `gnt`=0.
- A lone requester is never preempted. The hold timer only triggers when competition exists.
- A new request or a dropped request takes effect at the next edge. Simultaneous requests are resolved purely by `ptr`.
- `gnt_idx` is combinational from registered `gnt` through `encoder4x2`. `gnt` is guaranteed one-hot or zero, so the encoder's multi-hot behaviour is never exercised.
- Reset asserted mid-grant: all outputs go to their reset values immediately (asynchronous clear), and `ptr` returns to 0.

## Timing
- Request to grant: `req` sampled high at edge N in IDLE gives `gnt`/`gnt_vld`/`gnt_idx` valid after edge N+1… more precisely, they are valid after edge N, i.e. one cycle of latency.
- Release: `req[o]` sampled low at edge M gives `gnt`=0 after M. The earliest next grant appears after M+1.
- Preemption: the owner holds for exactly `HOLD_MAX` cycles, then `gnt`=0 for one cycle, then the next requester in round-robin order is granted.
- `act_cnt` updates one edge after the `gnt_idx` change it counts.

## Configuration
- `ENC_ARB_ACT_CNT_EN` defined:
  - A register holds the previous `gnt_idx`.
  - Each edge, `act_cnt` += popcount(`gnt_idx` XOR previous), saturating at 2^CNT_W-1.
  - The counter is cleared only by reset.
- `ENC_ARB_ACT_CNT_EN` undefined: the port stays present and is tied to 0, and no counter logic is built.

## Structure
- Shared package `enc_arb_pkg`:
  - State typedef (IDLE, GRANT).
  - Requester count constant (4).
  - Index width (2).
- A single sub-module: the existing `encoder4x2` for `gnt`→`gnt_idx`.
- Arbitration, hold timer and activity counter are inline.

## Test plan
- Reset and single request:
  - Reset, then `req`=0001 held for 5 cycles.
  - Expect `gnt`=0001 and `gnt_idx`=00 one cycle after `req` rises.
  - Expect `gnt`=0 one cycle after `req` drops, with `act_cnt` unchanged.
- Round-robin order:
  - `req`=1111 held, each owner dropping its request after 2 cycles of grant.
  - Expect grant order 0001, 0010, 0100, 1000, 0001, with one zero cycle between grants.
- Preemption:
  - `HOLD_MAX`=8, `req`=0011 held constant.
  - Expect owner 0 for 8 cycles, then 1 zero cycle, then owner 1 for 8 cycles, alternating.
- Lone owner:
  - `req`=0100 held for 30 cycles.
  - Expect `gnt`=0100 for all cycles after the first, with no preemption.
- Async reset mid-grant:
  - Assert `rst_n`=0 between edges while `gnt`=1000.
  - Expect `gnt`, `gnt_idx` and `act_cnt` at 0 immediately.
  - After release with `req`=1001, expect `gnt`=0001 (`ptr`=0).
- Activity counter (macro defined):
  - Grants to idx 0, 3, 0 with zero gaps in between.
  - Expect `act_cnt`=4.
  - With `CNT_W`=2, expect saturation at 3.
  - Macro undefined: `act_cnt`=0 throughout.
